// File: rtl/mmio_periph_pkg.sv
// Shared address map and status-word layout for the PUCRS_RV I/O responder.
package mmio_periph_pkg;

    localparam logic [31:0] MMIO_TX_ADDR     = 32'h8000_4000;
    localparam logic [31:0] MMIO_TX_ALT_ADDR = 32'h8000_1000;
    localparam logic [31:0] MMIO_STATUS_ADDR = 32'h8000_5000;
    localparam logic [31:0] MMIO_TIMER_ADDR  = 32'h8000_6000;
    localparam logic [31:0] MMIO_HALT_ADDR   = 32'h8000_0000;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  count;
        logic [4:0]  rsvd_lo;
        logic        ovf;
        logic        full;
        logic        empty;
    } status_t;

    function automatic status_t make_status(input logic [7:0] count,
                                            input logic ovf,
                                            input logic full,
                                            input logic empty);
        status_t s;
        s         = '0;
        s.count   = count;
        s.ovf     = ovf;
        s.full    = full;
        s.empty   = empty;
        return s;
    endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// Console TX byte FIFO; registered head output, pointers one bit wider than the index.
module mmio_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is only taken when the head leaves on the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_periph.sv
// Memory-mapped I/O target: console TX FIFO, prescaled timer, status and halt registers.
module mmio_periph
    import mmio_periph_pkg::*;
#(
    parameter logic [31:0] TX_ADDR     = MMIO_TX_ADDR,
    parameter logic [31:0] TX_ALT_ADDR = MMIO_TX_ALT_ADDR,
    parameter logic [31:0] STATUS_ADDR = MMIO_STATUS_ADDR,
    parameter logic [31:0] TIMER_ADDR  = MMIO_TIMER_ADDR,
    parameter logic [31:0] HALT_ADDR   = MMIO_HALT_ADDR,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TIMER_DIV   = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic [31:0] read_address,
    input  logic [3:0]  write,
    input  logic [31:0] write_address,
    input  logic [31:0] data_write,
    output logic [31:0] data_read,
    output logic        rd_hit,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] halt_code
);

    localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PW       = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TIMER_DIV - 1);

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          tx_push;
    logic          tx_pop;
    logic          timer_clr;
    logic          halt_wr;
    logic          status_rd;
    logic          ovf;
    logic [PW-1:0] prescaler;
    logic [31:0]   timer;
    logic          rd_mapped;
    logic [31:0]   rd_value;
    status_t       status_word;

    assign tx_push   = write[0] & ((write_address == TX_ADDR) | (write_address == TX_ALT_ADDR));
    assign tx_pop    = tx_valid & tx_ready;
    assign timer_clr = (|write) & (write_address == TIMER_ADDR);
    assign halt_wr   = (|write) & (write_address == HALT_ADDR);
    assign status_rd = read & (read_address == STATUS_ADDR);
    assign tx_valid  = ~fifo_empty;

    mmio_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .din   (data_write[7:0]),
        .pop   (tx_pop),
        .dout  (tx_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign status_word = make_status(8'(fifo_count), ovf, fifo_full, fifo_empty);

    always_comb begin
        rd_mapped = 1'b0;
        rd_value  = '0;
        if (read) begin
            if (read_address == STATUS_ADDR) begin
                rd_mapped = 1'b1;
                rd_value  = status_word;
            end else if (read_address == TIMER_ADDR) begin
                rd_mapped = 1'b1;
                rd_value  = timer;
            end else if ((read_address == TX_ADDR) || (read_address == TX_ALT_ADDR) ||
                         (read_address == HALT_ADDR)) begin
                rd_mapped = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_hit    <= 1'b0;
            data_read <= '0;
        end else begin
            rd_hit    <= rd_mapped;
            data_read <= rd_value;
        end
    end

    // A fresh overflow on the same edge as a STATUS read keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (tx_push & fifo_full & ~tx_pop) begin
            ovf <= 1'b1;
        end else if (status_rd) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            timer     <= '0;
        end else if (timer_clr) begin
            prescaler <= '0;
            timer     <= '0;
        end else if (prescaler == PRE_MAX) begin
            prescaler <= '0;
            timer     <= timer + 32'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halt      <= 1'b0;
            halt_code <= '0;
        end else if (halt_wr && !halt) begin
            halt      <= 1'b1;
            halt_code <= data_write;
        end
    end

endmodule

// File: tb/tb_mmio_periph.sv
// Directed bench for mmio_periph: vector table for decode/reads/TX, hand sequences for FIFO, timer and halt.
module tb_mmio_periph;

    localparam logic [31:0] A_TX     = 32'h8000_4000;
    localparam logic [31:0] A_TX_ALT = 32'h8000_1000;
    localparam logic [31:0] A_STATUS = 32'h8000_5000;
    localparam logic [31:0] A_TIMER  = 32'h8000_6000;
    localparam logic [31:0] A_HALT   = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        read;
    logic [31:0] read_address;
    logic [3:0]  write;
    logic [31:0] write_address;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        rd_hit;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;
    logic [31:0] halt_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_periph #(
        .FIFO_DEPTH (16),
        .TIMER_DIV  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .read          (read),
        .read_address  (read_address),
        .write         (write),
        .write_address (write_address),
        .data_write    (data_write),
        .data_read     (data_read),
        .rd_hit        (rd_hit),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .halt          (halt),
        .halt_code     (halt_code)
    );

    typedef struct {
        logic        rd;
        logic [31:0] raddr;
        logic [3:0]  we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        ready;
        logic        exp_hit;
        logic [31:0] exp_data;
        logic        exp_valid;
        logic [7:0]  exp_txd;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        read          = 1'b0;
        read_address  = '0;
        write         = '0;
        write_address = '0;
        data_write    = '0;
    endtask

    task automatic do_read(input logic [31:0] addr);
        idle();
        read         = 1'b1;
        read_address = addr;
        tick();
        idle();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        idle();
        write         = 4'b0001;
        write_address = addr;
        data_write    = data;
        tick();
        idle();
    endtask

    function automatic vec_t mk(input logic rd, input logic [31:0] raddr, input logic [3:0] we,
                                input logic [31:0] waddr, input logic [31:0] wdata,
                                input logic hit, input logic [31:0] d,
                                input logic v, input logic [7:0] txd);
        vec_t r;
        r.rd = rd; r.raddr = raddr; r.we = we; r.waddr = waddr; r.wdata = wdata;
        r.ready = 1'b1; r.exp_hit = hit; r.exp_data = d; r.exp_valid = v; r.exp_txd = txd;
        return r;
    endfunction

    initial begin
        vecs.push_back(mk(1, A_STATUS,     4'h0, '0,       '0,     1, 32'h1,   0, 8'h00));
        vecs.push_back(mk(1, 32'h80007000, 4'h1, A_TX,     32'h48, 0, 32'h0,   1, 8'h48));
        vecs.push_back(mk(1, A_TX,         4'hF, A_TX,     32'h69, 1, 32'h0,   1, 8'h69));
        vecs.push_back(mk(1, A_STATUS,     4'h0, '0,       '0,     1, 32'h100, 0, 8'h00));
        vecs.push_back(mk(1, A_HALT,       4'h2, A_TX,     32'h55, 1, 32'h0,   0, 8'h00));
        vecs.push_back(mk(1, A_STATUS,     4'h0, '0,       '0,     1, 32'h1,   0, 8'h00));
        vecs.push_back(mk(0, A_STATUS,     4'h1, A_TIMER,  32'h0,  0, 32'h0,   0, 8'h00));
        vecs.push_back(mk(1, A_TIMER,      4'h0, '0,       '0,     1, 32'h0,   0, 8'h00));
        vecs.push_back(mk(1, A_STATUS,     4'h1, A_TX_ALT, 32'h7E, 1, 32'h1,   1, 8'h7E));
        vecs.push_back(mk(1, A_STATUS,     4'h0, '0,       '0,     1, 32'h100, 0, 8'h00));
        vecs.push_back(mk(1, 32'h80005001, 4'h0, '0,       '0,     0, 32'h0,   0, 8'h00));

        // Reset state
        idle();
        tx_ready = 1'b0;
        reset    = 1'b0;
        repeat (3) tick();
        check("reset data_read", data_read, 32'h0);
        check("reset rd_hit", {31'b0, rd_hit}, 32'h0);
        check("reset tx_valid", {31'b0, tx_valid}, 32'h0);
        check("reset tx_data", {24'b0, tx_data}, 32'h0);
        check("reset halt", {31'b0, halt}, 32'h0);
        check("reset halt_code", halt_code, 32'h0);
        reset = 1'b1;
        tick();

        // Vector table: decode, read latency, TX push/pop
        for (int i = 0; i < vecs.size(); i++) begin
            read          = vecs[i].rd;
            read_address  = vecs[i].raddr;
            write         = vecs[i].we;
            write_address = vecs[i].waddr;
            data_write    = vecs[i].wdata;
            tx_ready      = vecs[i].ready;
            tick();
            check($sformatf("vec%0d rd_hit", i), {31'b0, rd_hit}, {31'b0, vecs[i].exp_hit});
            check($sformatf("vec%0d data_read", i), data_read, vecs[i].exp_data);
            check($sformatf("vec%0d tx_valid", i), {31'b0, tx_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d tx_data", i), {24'b0, tx_data}, {24'b0, vecs[i].exp_txd});
        end
        idle();

        // Overflow: 17 pushes into a stalled FIFO
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) do_write(A_TX, i);
        do_read(A_STATUS);
        check("ovf status", data_read, 32'h0000_1006);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d valid", i), {31'b0, tx_valid}, 32'h1);
            check($sformatf("drain%0d data", i), {24'b0, tx_data}, i);
            tick();
        end
        check("drain empty", {31'b0, tx_valid}, 32'h0);
        do_read(A_STATUS);
        check("ovf cleared status", data_read, 32'h0000_0001);

        // Push into a full FIFO while the head is popped
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) do_write(A_TX, 32'h20 + i);
        do_read(A_STATUS);
        check("full status", data_read, 32'h0000_1002);
        check("full head", {24'b0, tx_data}, 32'h20);
        tx_ready = 1'b1;
        do_write(A_TX, 32'hAA);
        tx_ready = 1'b0;
        do_read(A_STATUS);
        check("push-pop status", data_read, 32'h0000_1002);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("pp%0d data", i), {24'b0, tx_data}, (i == 15) ? 32'hAA : 32'h21 + i);
            tick();
        end
        check("pp empty", {31'b0, tx_valid}, 32'h0);

        // Timer: clear, 40 cycles at divide-by-4, then clear again
        do_write(A_TIMER, 32'h0);
        repeat (40) tick();
        do_read(A_TIMER);
        check("timer 40 cycles", data_read, 32'd10);
        do_write(A_TIMER, 32'h0);
        do_read(A_TIMER);
        check("timer cleared", data_read, 32'd0);

        // Halt is sticky and keeps the first code
        do_write(A_HALT, 32'h1);
        check("halt set", {31'b0, halt}, 32'h1);
        check("halt code", halt_code, 32'h1);
        do_write(A_HALT, 32'h5);
        check("halt still set", {31'b0, halt}, 32'h1);
        check("halt code kept", halt_code, 32'h1);

        // Async reset while draining
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) do_write(A_TX, 32'h30 + i);
        tx_ready = 1'b1;
        tick();
        check("post-halt drain", {24'b0, tx_data}, 32'h31);
        read         = 1'b1;
        read_address = A_STATUS;
        #2 reset = 1'b0;
        #1;
        check("async tx_valid", {31'b0, tx_valid}, 32'h0);
        check("async halt", {31'b0, halt}, 32'h0);
        check("async halt_code", halt_code, 32'h0);
        check("async rd_hit", {31'b0, rd_hit}, 32'h0);
        idle();
        tick();
        reset = 1'b1;
        tick();
        do_read(A_STATUS);
        check("after reset status", data_read, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
